// File: rtl/deflate_stage_sequencer.sv
// deflate_stage_sequencer
//   Sequences the LZ77 search, Huffman build and bitstream emit stages for each
//   deflate block. It loops over blocks until the final block is emitted, and
//   guards every stage with a watchdog and a done-pulse protocol checker.
// Ports:
//   clk, reset              clock; synchronous active-high reset
//   start, abort, clear     host controls (begin stream / cancel / leave ERR)
//   last_block              upstream level, sampled when emit_done is accepted
//   timeout_cycles          per-stage cycle limit, 0 disables the watchdog
//   *_start / *_done        one-cycle handshake pulses to/from the stage engines
//   busy, done, error       stream status (done is a one-cycle pulse)
//   block_count             blocks completed in the current stream (saturating)
//   state                   encoded FSM state for debug
module deflate_stage_sequencer #(
  parameter int unsigned TIMEOUT_W   = 20,
  parameter int unsigned BLOCK_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   clear,
  input  logic                   last_block,
  input  logic [TIMEOUT_W-1:0]   timeout_cycles,
  output logic                   lz_start,
  input  logic                   lz_done,
  output logic                   huff_start,
  input  logic                   huff_done,
  output logic                   emit_start,
  input  logic                   emit_done,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [BLOCK_CNT_W-1:0] block_count,
  output logic [2:0]             state
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LZ     = 3'd1,
    ST_HUFF   = 3'd2,
    ST_EMIT   = 3'd3,
    ST_FINISH = 3'd4,
    ST_ERR    = 3'd5
  } state_e;

  state_e                 state_q, state_d;
  logic                   lz_start_q, lz_start_d;
  logic                   huff_start_q, huff_start_d;
  logic                   emit_start_q, emit_start_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;
  logic [BLOCK_CNT_W-1:0] blk_q, blk_d;
  logic [TIMEOUT_W-1:0]   wdog_q, wdog_d;

  logic                   stage_first;
  logic                   cur_done;
  logic                   other_done;
  logic [TIMEOUT_W-1:0]   wdog_inc;
  logic                   timeout_hit;

  // A start pulse is still high during the first cycle of its stage; dones
  // arriving in that cycle are ignored.
  assign stage_first = lz_start_q | huff_start_q | emit_start_q;

  // wdog_inc counts stage cycles including the current one.
  assign wdog_inc    = wdog_q + TIMEOUT_W'(1);
  assign timeout_hit = (timeout_cycles != '0) && (wdog_inc == timeout_cycles);

  // Split incoming dones into the current stage's done and foreign dones.
  always_comb begin
    cur_done   = 1'b0;
    other_done = 1'b0;
    case (state_q)
      ST_LZ: begin
        cur_done   = lz_done;
        other_done = huff_done | emit_done;
      end
      ST_HUFF: begin
        cur_done   = huff_done;
        other_done = lz_done | emit_done;
      end
      ST_EMIT: begin
        cur_done   = emit_done;
        other_done = lz_done | huff_done;
      end
      default: ;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    lz_start_d   = 1'b0;
    huff_start_d = 1'b0;
    emit_start_d = 1'b0;
    done_d       = 1'b0;
    blk_d        = blk_q;
    wdog_d       = wdog_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d    = ST_LZ;
          lz_start_d = 1'b1;
          blk_d      = '0;
          wdog_d     = '0;
        end
      end
      ST_LZ, ST_HUFF, ST_EMIT: begin
        // Priority: abort, protocol error, accepted done, watchdog.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (!stage_first && other_done) begin
          state_d = ST_ERR;
        end else if (!stage_first && cur_done) begin
          wdog_d = '0;
          case (state_q)
            ST_LZ: begin
              state_d      = ST_HUFF;
              huff_start_d = 1'b1;
            end
            ST_HUFF: begin
              state_d      = ST_EMIT;
              emit_start_d = 1'b1;
            end
            default: begin
              blk_d = (blk_q == '1) ? blk_q : blk_q + BLOCK_CNT_W'(1);
              if (last_block) begin
                state_d = ST_FINISH;
                done_d  = 1'b1;
              end else begin
                state_d    = ST_LZ;
                lz_start_d = 1'b1;
              end
            end
          endcase
        end else if (timeout_hit) begin
          state_d = ST_ERR;
        end else begin
          wdog_d = wdog_inc;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      ST_ERR: begin
        if (clear) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d  = (state_d == ST_LZ) || (state_d == ST_HUFF) ||
              (state_d == ST_EMIT) || (state_d == ST_FINISH);
    error_d = (state_d == ST_ERR);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      lz_start_q   <= 1'b0;
      huff_start_q <= 1'b0;
      emit_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      blk_q        <= '0;
      wdog_q       <= '0;
    end else begin
      state_q      <= state_d;
      lz_start_q   <= lz_start_d;
      huff_start_q <= huff_start_d;
      emit_start_q <= emit_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      blk_q        <= blk_d;
      wdog_q       <= wdog_d;
    end
  end

  assign lz_start    = lz_start_q;
  assign huff_start  = huff_start_q;
  assign emit_start  = emit_start_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign block_count = blk_q;
  assign state       = state_q;

endmodule

// File: tb/tb_deflate_stage_sequencer.sv
// Testbench for deflate_stage_sequencer: cycle-by-cycle vector table plus
// hand-written watchdog, long-stall and block-count saturation sequences.
module tb_deflate_stage_sequencer;

  localparam int unsigned TW = 20;
  localparam int unsigned BW = 16;

  // Input pattern bits: {reset, start, abort, clear, last_block, lz_done, huff_done, emit_done}
  localparam logic [7:0] N   = 8'h00;
  localparam logic [7:0] RST = 8'h80;
  localparam logic [7:0] ST  = 8'h40;
  localparam logic [7:0] AB  = 8'h20;
  localparam logic [7:0] CL  = 8'h10;
  localparam logic [7:0] LB  = 8'h08;
  localparam logic [7:0] LZ  = 8'h04;
  localparam logic [7:0] HD  = 8'h02;
  localparam logic [7:0] ED  = 8'h01;

  // Expected flag bits: {lz_start, huff_start, emit_start, busy, done, error}
  localparam logic [5:0] F_0   = 6'b000000;
  localparam logic [5:0] F_LZS = 6'b100100;
  localparam logic [5:0] F_HS  = 6'b010100;
  localparam logic [5:0] F_ES  = 6'b001100;
  localparam logic [5:0] F_B   = 6'b000100;
  localparam logic [5:0] F_DN  = 6'b000110;
  localparam logic [5:0] F_ER  = 6'b000001;

  localparam logic [2:0] S_I = 3'd0;
  localparam logic [2:0] S_L = 3'd1;
  localparam logic [2:0] S_H = 3'd2;
  localparam logic [2:0] S_E = 3'd3;
  localparam logic [2:0] S_F = 3'd4;
  localparam logic [2:0] S_R = 3'd5;

  logic          clk = 1'b0;
  logic          reset, start, abort, clear, last_block;
  logic          lz_done, huff_done, emit_done;
  logic [TW-1:0] timeout_cycles;
  logic          lz_start, huff_start, emit_start, busy, done, error;
  logic [BW-1:0] block_count;
  logic [2:0]    state;

  // Second instance with a 2-bit block counter, driven identically, to reach saturation.
  logic          s_lz_start, s_huff_start, s_emit_start, s_busy, s_done, s_error;
  logic [1:0]    s_block_count;
  logic [2:0]    s_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  deflate_stage_sequencer #(.TIMEOUT_W(TW), .BLOCK_CNT_W(BW)) u_dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .clear(clear),
    .last_block(last_block), .timeout_cycles(timeout_cycles),
    .lz_start(lz_start), .lz_done(lz_done),
    .huff_start(huff_start), .huff_done(huff_done),
    .emit_start(emit_start), .emit_done(emit_done),
    .busy(busy), .done(done), .error(error),
    .block_count(block_count), .state(state)
  );

  deflate_stage_sequencer #(.TIMEOUT_W(TW), .BLOCK_CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .clear(clear),
    .last_block(last_block), .timeout_cycles(timeout_cycles),
    .lz_start(s_lz_start), .lz_done(lz_done),
    .huff_start(s_huff_start), .huff_done(huff_done),
    .emit_start(s_emit_start), .emit_done(emit_done),
    .busy(s_busy), .done(s_done), .error(s_error),
    .block_count(s_block_count), .state(s_state)
  );

  typedef struct {
    logic [7:0]    in;
    logic [2:0]    st;
    logic [5:0]    fl;
    logic [BW-1:0] blk;
  } vec_t;

  vec_t tbl[$];

  function automatic void v(input logic [7:0] in, input logic [2:0] st,
                            input logic [5:0] fl, input logic [BW-1:0] blk);
    vec_t r;
    r.in  = in;
    r.st  = st;
    r.fl  = fl;
    r.blk = blk;
    tbl.push_back(r);
  endfunction

  task automatic drive(input logic [7:0] in);
    {reset, start, abort, clear, last_block, lz_done, huff_done, emit_done} = in;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] obs();
    return 64'({state, lz_start, huff_start, emit_start, busy, done, error, block_count});
  endfunction

  initial begin
    drive(N);
    timeout_cycles = '0;

    // Reset and single block, each done 3 cycles after its start pulse
    v(RST,     S_I, F_0,   0);
    v(ST,      S_L, F_LZS, 0);
    v(N,       S_L, F_B,   0);
    v(N,       S_L, F_B,   0);
    v(LZ,      S_H, F_HS,  0);
    v(N,       S_H, F_B,   0);
    v(N,       S_H, F_B,   0);
    v(HD,      S_E, F_ES,  0);
    v(N,       S_E, F_B,   0);
    v(N,       S_E, F_B,   0);
    v(ED | LB, S_F, F_DN,  1);
    v(N,       S_I, F_0,   1);
    // Three-block stream; start clears the old count
    v(ST,      S_L, F_LZS, 0);
    v(N,       S_L, F_B,   0);
    v(LZ,      S_H, F_HS,  0);
    v(N,       S_H, F_B,   0);
    v(HD,      S_E, F_ES,  0);
    v(N,       S_E, F_B,   0);
    v(ED,      S_L, F_LZS, 1);
    v(N,       S_L, F_B,   1);
    v(LZ,      S_H, F_HS,  1);
    v(N,       S_H, F_B,   1);
    v(HD,      S_E, F_ES,  1);
    v(N,       S_E, F_B,   1);
    v(ED,      S_L, F_LZS, 2);
    v(N,       S_L, F_B,   2);
    v(LZ,      S_H, F_HS,  2);
    v(N,       S_H, F_B,   2);
    v(HD,      S_E, F_ES,  2);
    v(N,       S_E, F_B,   2);
    v(ED | LB, S_F, F_DN,  3);
    v(N,       S_I, F_0,   3);
    // Protocol: done in the start cycle ignored, foreign dones -> ERR
    v(ST,      S_L, F_LZS, 0);
    v(LZ,      S_L, F_B,   0);
    v(ED,      S_R, F_ER,  0);
    v(ST,      S_R, F_ER,  0);
    v(CL,      S_I, F_0,   0);
    v(ST,      S_L, F_LZS, 0);
    v(N,       S_L, F_B,   0);
    v(LZ | HD, S_R, F_ER,  0);
    v(CL,      S_I, F_0,   0);
    // Abort beats emit_done; start+abort in IDLE stays IDLE
    v(ST,      S_L, F_LZS, 0);
    v(N,       S_L, F_B,   0);
    v(LZ,      S_H, F_HS,  0);
    v(N,       S_H, F_B,   0);
    v(HD,      S_E, F_ES,  0);
    v(N,       S_E, F_B,   0);
    v(ED|AB|LB,S_I, F_0,   0);
    v(ST | AB, S_I, F_0,   0);
    // Reset in HUFF, then a clean stream
    v(ST,      S_L, F_LZS, 0);
    v(N,       S_L, F_B,   0);
    v(LZ,      S_H, F_HS,  0);
    v(N,       S_H, F_B,   0);
    v(RST | HD,S_I, F_0,   0);
    v(ST,      S_L, F_LZS, 0);
    v(N,       S_L, F_B,   0);
    v(LZ,      S_H, F_HS,  0);
    v(N,       S_H, F_B,   0);
    v(HD,      S_E, F_ES,  0);
    v(N,       S_E, F_B,   0);
    v(ED | LB, S_F, F_DN,  1);
    v(N,       S_I, F_0,   1);
    v(RST,     S_I, F_0,   0);
    v(N,       S_I, F_0,   0);

    foreach (tbl[i]) begin
      drive(tbl[i].in);
      tick();
      chk($sformatf("vec%0d", i), obs(), 64'({tbl[i].st, tbl[i].fl, tbl[i].blk}));
    end
    drive(N);

    // Watchdog: 10 HUFF cycles then ERR; start ignored in ERR; clear exits
    timeout_cycles = TW'(10);
    drive(ST); tick();
    drive(N);  tick();
    drive(LZ); tick();
    chk("tmo_enter_huff", 64'(state), 64'(S_H));
    drive(N);
    for (int k = 2; k <= 10; k++) begin
      tick();
      chk($sformatf("tmo_huff_c%0d", k), 64'(state), 64'(S_H));
    end
    tick();
    chk("tmo_err", 64'({state, busy, error}), 64'({S_R, 1'b0, 1'b1}));
    drive(ST); tick();
    chk("tmo_start_ignored", 64'({state, lz_start, error}), 64'({S_R, 1'b0, 1'b1}));
    drive(CL); tick();
    chk("tmo_clear", 64'({state, error}), 64'({S_I, 1'b0}));

    // Watchdog disabled: 1000 cycles without huff_done stays in HUFF
    timeout_cycles = '0;
    drive(ST); tick();
    drive(N);  tick();
    drive(LZ); tick();
    drive(N);
    begin
      int off_cnt;
      off_cnt = 0;
      for (int k = 0; k < 1000; k++) begin
        tick();
        if (state !== S_H || error !== 1'b0) off_cnt++;
      end
      chk("nowdog_cycles_off_huff", 64'(off_cnt), 64'd0);
    end
    drive(AB); tick();
    chk("nowdog_abort", 64'({state, done, busy}), 64'({S_I, 1'b0, 1'b0}));

    // Done on the same cycle the count reaches the limit wins over timeout
    timeout_cycles = TW'(3);
    drive(ST); tick();
    drive(N);  tick();
    drive(LZ); tick();
    drive(N);  tick(); tick();
    drive(HD); tick();
    chk("tmo_done_wins", 64'({state, emit_start, error}), 64'({S_E, 1'b1, 1'b0}));
    drive(AB); tick();
    chk("tmo_done_wins_abort", 64'(state), 64'(S_I));

    // Five blocks: wide counter reaches 5, 2-bit counter saturates at 3
    timeout_cycles = '0;
    drive(ST); tick();
    for (int b = 0; b < 5; b++) begin
      drive(N);  tick();
      drive(LZ); tick();
      drive(N);  tick();
      drive(HD); tick();
      drive(N);  tick();
      drive((b == 4) ? (ED | LB) : ED); tick();
      chk($sformatf("sat_blk%0d_count", b), 64'(block_count), 64'(b + 1));
      chk($sformatf("sat_blk%0d_narrow", b), 64'(s_block_count), 64'((b + 1 > 3) ? 3 : b + 1));
    end
    chk("sat_finish", 64'({state, done}), 64'({S_F, 1'b1}));
    drive(N); tick();
    chk("sat_idle", 64'({state, done, block_count}), 64'({S_I, 1'b0, 16'd5}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
